// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// seq_pkg
// Shared FSM encoding and song-ROM field layout for the pattern sequencer.
// Revision: 1.0
// ============================================================================
package seq_pkg;

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_order_addr = 3'd1;
    localparam logic [2:0] c_st_order_data = 3'd2;
    localparam logic [2:0] c_st_row_addr   = 3'd3;
    localparam logic [2:0] c_st_row_data   = 3'd4;
    localparam logic [2:0] c_st_emit       = 3'd5;

    localparam int c_note_w  = 6;
    localparam int c_len_w   = 5;
    localparam int c_instr_w = 4;

    // Row word fields
    localparam int c_note_lsb  = 0;
    localparam int c_len_lsb   = 6;
    localparam int c_instr_lsb = 11;

    // Order word fields
    localparam int c_optr_lsb = 0;
    localparam int c_olen_lsb = 8;
    localparam int c_ofield_w = 8;

endpackage
`default_nettype wire

// File: rtl/seq_channel_state.sv
`default_nettype none
// ============================================================================
// seq_channel_state
// One channel's order index, row index and note-hold tick counter.
// Revision: 1.0
// ============================================================================
module seq_channel_state
    import seq_pkg::*;
#(
    parameter int ORDER_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               dec_i,
    input  logic               load_i,
    input  logic [c_len_w-1:0] load_val_i,
    input  logic               wr_idx_i,
    input  logic [ORDER_W-1:0] order_d_i,
    input  logic [7:0]         row_d_i,
    output logic [ORDER_W-1:0] order_idx_o,
    output logic [7:0]         row_idx_o,
    output logic [c_len_w-1:0] count_o
);

    logic [ORDER_W-1:0] order_idx_q, order_idx_d;
    logic [7:0]         row_idx_q, row_idx_d;
    logic [c_len_w-1:0] count_q, count_d;

    always_comb begin
        order_idx_d = order_idx_q;
        row_idx_d   = row_idx_q;
        count_d     = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - c_len_w'(1);
        end
        if (wr_idx_i) begin
            order_idx_d = order_d_i;
            row_idx_d   = row_d_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            order_idx_q <= '0;
            row_idx_q   <= '0;
            count_q     <= '0;
        end else begin
            order_idx_q <= order_idx_d;
            row_idx_q   <= row_idx_d;
            count_q     <= count_d;
        end
    end

    assign order_idx_o = order_idx_q;
    assign row_idx_o   = row_idx_q;
    assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/multi_channel_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// multi_channel_pattern_sequencer
// Services tick-due channels one at a time over a shared song-ROM read port.
// Revision: 1.0
// ============================================================================
module multi_channel_pattern_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int ORDER_DEPTH  = 16,
    parameter int ORDER_BASE   = 0,
    parameter int PATTERN_BASE = 64,
    localparam int c_ch_w      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_tick,
    output logic                  o_note_valid,
    output logic [c_ch_w-1:0]     o_channel,
    output logic [c_note_w-1:0]   o_note,
    output logic [c_len_w-1:0]    o_note_len,
    output logic [c_instr_w-1:0]  o_instrument,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [15:0]           i_rom_data
);

    localparam int c_order_w = $clog2(ORDER_DEPTH);

    logic [2:0]              state_q, state_d;
    logic [c_ch_w-1:0]       ch_q, ch_d;
    logic [NUM_CHANNELS-1:0] pend_q, pend_d;
    logic [7:0]              ptr_q, ptr_d;
    logic [7:0]              plen_q, plen_d;
    logic [c_note_w-1:0]     note_q, note_d;
    logic [c_len_w-1:0]      len_q, len_d;
    logic [c_instr_w-1:0]    instr_q, instr_d;
    logic                    overrun_q, overrun_d;

    logic [c_order_w-1:0]    w_order_idx [NUM_CHANNELS];
    logic [7:0]              w_row_idx   [NUM_CHANNELS];
    logic [c_len_w-1:0]      w_count     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_zero, w_dec, w_load, w_wr_idx;
    logic [c_order_w-1:0]    w_order_d, w_cur_order;
    logic [7:0]              w_row_d, w_cur_row;
    logic [c_len_w-1:0]      w_load_val;
    logic [NUM_CHANNELS-1:0] w_pend_rest;
    logic [7:0]              w_rom_olen;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_order_addr, w_row_addr;

    function automatic logic [c_ch_w-1:0] f_lowest(input logic [NUM_CHANNELS-1:0] m);
        f_lowest = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = c_ch_w'(i);
        end
    endfunction

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
            seq_channel_state #(
                .ORDER_W (c_order_w)
            ) u_ch (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .dec_i       (w_dec[g]),
                .load_i      (w_load[g]),
                .load_val_i  (w_load_val),
                .wr_idx_i    (w_wr_idx[g]),
                .order_d_i   (w_order_d),
                .row_d_i     (w_row_d),
                .order_idx_o (w_order_idx[g]),
                .row_idx_o   (w_row_idx[g]),
                .count_o     (w_count[g])
            );
            assign w_zero[g] = (w_count[g] == '0);
        end
    endgenerate

    assign w_accept    = i_enable && i_tick && (state_q == c_st_idle);
    // Due channels are captured; every other channel spends one tick of its note.
    assign w_dec       = w_accept ? ~w_zero : '0;
    assign w_cur_order = w_order_idx[ch_q];
    assign w_cur_row   = w_row_idx[ch_q];
    assign w_pend_rest = pend_q & ~(NUM_CHANNELS'(1) << ch_q);
    assign w_load_val  = i_rom_data[c_len_lsb +: c_len_w];
    assign w_rom_olen  = i_rom_data[c_olen_lsb +: c_ofield_w];

    assign w_order_addr = ADDR_WIDTH'(ORDER_BASE + int'(ch_q) * ORDER_DEPTH + int'(w_cur_order));
    assign w_row_addr   = ADDR_WIDTH'(PATTERN_BASE + int'(ptr_q) + int'(w_cur_row));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pend_d    = pend_q;
        ptr_d     = ptr_q;
        plen_d    = plen_q;
        note_d    = note_q;
        len_d     = len_q;
        instr_d   = instr_q;
        overrun_d = overrun_q | (i_enable && i_tick && (state_q != c_st_idle));
        w_load    = '0;
        w_wr_idx  = '0;
        w_order_d = w_cur_order;
        w_row_d   = w_cur_row;

        case (state_q)
            c_st_idle: begin
                if (pend_q != '0) begin
                    ch_d    = f_lowest(pend_q);
                    state_d = c_st_order_addr;
                end
                if (w_accept) pend_d = w_zero;
            end
            c_st_order_addr: state_d = c_st_order_data;
            c_st_order_data: begin
                ptr_d  = i_rom_data[c_optr_lsb +: c_ofield_w];
                plen_d = w_rom_olen;
                if (w_rom_olen != '0) begin
                    state_d = c_st_row_addr;
                end else if (w_cur_order != '0) begin
                    w_wr_idx[ch_q] = 1'b1;
                    w_order_d      = '0;
                    state_d        = c_st_order_addr;
                end else begin
                    // Empty first order entry: channel is muted this tick.
                    pend_d = w_pend_rest;
                    if (w_pend_rest != '0) begin
                        ch_d    = f_lowest(w_pend_rest);
                        state_d = c_st_order_addr;
                    end else begin
                        state_d = c_st_idle;
                    end
                end
            end
            c_st_row_addr: state_d = c_st_row_data;
            c_st_row_data: begin
                note_d         = i_rom_data[c_note_lsb +: c_note_w];
                len_d          = w_load_val;
                instr_d        = i_rom_data[c_instr_lsb +: c_instr_w];
                w_load[ch_q]   = 1'b1;
                w_wr_idx[ch_q] = 1'b1;
                if (({1'b0, w_cur_row} + 9'd1) == {1'b0, plen_q}) begin
                    w_row_d   = '0;
                    w_order_d = w_cur_order + c_order_w'(1);
                end else begin
                    w_row_d = w_cur_row + 8'd1;
                end
                state_d = c_st_emit;
            end
            c_st_emit: begin
                pend_d = w_pend_rest;
                if (w_pend_rest != '0) begin
                    ch_d    = f_lowest(w_pend_rest);
                    state_d = c_st_order_addr;
                end else begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= c_st_idle;
            ch_q      <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            plen_q    <= '0;
            note_q    <= '0;
            len_q     <= '0;
            instr_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            plen_q    <= plen_d;
            note_q    <= note_d;
            len_q     <= len_d;
            instr_q   <= instr_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_note_valid = (state_q == c_st_emit);
    assign o_channel    = (state_q == c_st_emit) ? ch_q : '0;
    assign o_note       = note_q;
    assign o_note_len   = len_q;
    assign o_instrument = instr_q;
    assign o_busy       = (state_q != c_st_idle);
    assign o_overrun    = overrun_q;
    assign o_rom_addr   = (state_q == c_st_order_addr) ? w_order_addr :
                          (state_q == c_st_row_addr)   ? w_row_addr   : '0;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// tb_multi_channel_pattern_sequencer
// Directed and randomized checks against a tick-level behavioural song model.
// Revision: 1.0
// ============================================================================
module tb_multi_channel_pattern_sequencer;

    localparam int NCH = 4;
    localparam int AW  = 10;
    localparam int OD  = 16;
    localparam int OB  = 0;
    localparam int PB  = 64;
    localparam int W   = 40;

    logic        clk = 1'b0;
    logic        i_rst, i_enable, i_tick;
    logic        o_note_valid, o_busy, o_overrun;
    logic [1:0]  o_channel;
    logic [5:0]  o_note;
    logic [4:0]  o_note_len;
    logic [3:0]  o_instrument;
    logic [AW-1:0] o_rom_addr;
    logic [15:0] rom_q;
    logic [15:0] rom [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= rom[o_rom_addr];

    multi_channel_pattern_sequencer #(
        .NUM_CHANNELS (NCH), .ADDR_WIDTH (AW), .ORDER_DEPTH (OD),
        .ORDER_BASE (OB), .PATTERN_BASE (PB)
    ) dut (
        .i_clk (clk), .i_rst (i_rst), .i_enable (i_enable), .i_tick (i_tick),
        .o_note_valid (o_note_valid), .o_channel (o_channel), .o_note (o_note),
        .o_note_len (o_note_len), .o_instrument (o_instrument), .o_busy (o_busy),
        .o_overrun (o_overrun), .o_rom_addr (o_rom_addr), .i_rom_data (rom_q)
    );

    int checks = 0;
    int failures = 0;

    // Song-level model: per-channel position and remaining hold ticks.
    int m_oi [NCH];
    int m_ri [NCH];
    int m_cnt[NCH];
    int m_note, m_len, m_instr;
    int emit_cnt[NCH];
    int first_emit;

    // Expected per-cycle trace of one tick, indexed by cycles after acceptance.
    int e_addr[W+8];
    bit e_val [W+8];
    int e_ch  [W+8];
    int e_note[W+8];
    int e_len [W+8];
    int e_ins [W+8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_tick();
        bit pend[NCH];
        int s, oa, ra, olen, optr;
        logic [15:0] ow, rw;
        for (int d = 0; d < W + 8; d++) begin
            e_addr[d] = 0; e_val[d] = 0; e_ch[d] = 0;
            e_note[d] = 0; e_len[d] = 0; e_ins[d] = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            pend[c] = (m_cnt[c] == 0);
            if (m_cnt[c] != 0) m_cnt[c]--;
        end
        s = 1;
        for (int c = 0; c < NCH; c++) begin
            if (!pend[c]) continue;
            while (1) begin
                oa = (OB + c * OD + m_oi[c]) % 1024;
                e_addr[s] = oa;
                ow = rom[oa];
                olen = int'(ow[15:8]);
                optr = int'(ow[7:0]);
                if (olen == 0 && m_oi[c] != 0) begin
                    m_oi[c] = 0;
                    s += 2;
                    continue;
                end
                if (olen == 0) begin
                    s += 2;
                    break;
                end
                ra = (PB + optr + m_ri[c]) % 1024;
                e_addr[s+2] = ra;
                rw = rom[ra];
                e_val[s+4]  = 1'b1;
                e_ch[s+4]   = c;
                e_note[s+4] = int'(rw[5:0]);
                e_len[s+4]  = int'(rw[10:6]);
                e_ins[s+4]  = int'(rw[14:11]);
                m_cnt[c] = int'(rw[10:6]);
                m_ri[c]++;
                if (m_ri[c] == olen) begin
                    m_ri[c] = 0;
                    m_oi[c] = (m_oi[c] + 1) % OD;
                end
                s += 5;
                break;
            end
        end
    endfunction

    task automatic run_tick(input int dup);
        model_tick();
        first_emit = -1;
        i_tick = 1'b1;
        @(negedge clk);
        for (int d = 1; d <= W; d++) begin
            i_tick = (d == dup);
            @(negedge clk);
            if (e_val[d]) begin
                m_note = e_note[d]; m_len = e_len[d]; m_instr = e_ins[d];
                emit_cnt[e_ch[d]]++;
                if (first_emit < 0) first_emit = d;
                chk("channel", 32'(o_channel), e_ch[d]);
            end
            chk("rom_addr", 32'(o_rom_addr), e_addr[d]);
            chk("note_valid", 32'(o_note_valid), 32'(e_val[d]));
            chk("note", 32'(o_note), m_note);
            chk("note_len", 32'(o_note_len), m_len);
            chk("instrument", 32'(o_instrument), m_instr);
        end
        i_tick = 1'b0;
        chk("busy_after_tick", 32'(o_busy), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_tick = 1'b0; i_enable = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_oi[c] = 0; m_ri[c] = 0; m_cnt[c] = 0; emit_cnt[c] = 0;
        end
        m_note = 0; m_len = 0; m_instr = 0;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0;
    endtask

    task automatic set_order(input int c, input int idx, input int ptr, input int len);
        rom[OB + c * OD + idx] = {len[7:0], ptr[7:0]};
    endtask

    task automatic set_row(input int rel, input int note, input int len, input int ins);
        rom[PB + rel] = {1'b0, ins[3:0], len[4:0], note[5:0]};
    endtask

    task automatic setup_basic();
        rom_clear();
        set_order(0, 0, 0, 2);
        set_row(0, 10, 0, 3);
        set_row(1, 11, 1, 5);
        set_order(1, 0, 16, 1);
        set_row(16, 20, 0, 7);
    endtask

    initial begin
        int prev, pat;
        rom_clear();
        do_reset();

        // Reset state
        chk("rst_valid", 32'(o_note_valid), 0);
        chk("rst_channel", 32'(o_channel), 0);
        chk("rst_note", 32'(o_note), 0);
        chk("rst_len", 32'(o_note_len), 0);
        chk("rst_instr", 32'(o_instrument), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_overrun", 32'(o_overrun), 0);
        chk("rst_rom_addr", 32'(o_rom_addr), 0);

        // Two active channels: ch0 emits 5 cycles after acceptance, ch1 5 later
        setup_basic();
        run_tick(0);
        chk("basic_first_latency", first_emit, 5);
        chk("basic_ch0_emits", emit_cnt[0], 1);
        chk("basic_ch1_emits", emit_cnt[1], 1);
        run_tick(0);
        run_tick(0);

        // note_len=2 holds three ticks: emits on ticks 1 and 4 only
        do_reset();
        rom_clear();
        set_order(0, 0, 0, 1);
        set_row(0, 5, 2, 1);
        pat = 0;
        for (int t = 0; t < 5; t++) begin
            prev = emit_cnt[0];
            run_tick(0);
            pat = (pat << 1) | (emit_cnt[0] - prev);
        end
        chk("hold_pattern", pat, 32'b10010);

        // End marker at order[1] wraps back to order[0]
        do_reset();
        rom_clear();
        set_order(0, 0, 0, 1);
        set_row(0, 7, 0, 2);
        run_tick(0);
        run_tick(0);
        chk("wrap_latency", first_emit, 7);
        chk("wrap_emits", emit_cnt[0], 2);

        // Muted ch1, ticks while disabled are ignored
        do_reset();
        rom_clear();
        set_order(0, 0, 0, 1);
        set_row(0, 3, 0, 9);
        for (int t = 0; t < 10; t++) run_tick(0);
        chk("mute_ch1_emits", emit_cnt[1], 0);
        chk("mute_ch0_emits", emit_cnt[0], 10);
        i_enable = 1'b0; i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("disabled_busy", 32'(o_busy), 0);
            chk("disabled_valid", 32'(o_note_valid), 0);
        end
        chk("disabled_overrun", 32'(o_overrun), 0);
        i_enable = 1'b1;
        run_tick(0);

        // Tick while busy is dropped and flagged sticky
        do_reset();
        setup_basic();
        run_tick(2);
        chk("overrun_set", 32'(o_overrun), 1);
        chk("overrun_latency", first_emit, 5);
        run_tick(0);
        chk("overrun_sticky", 32'(o_overrun), 1);

        // Reset during ROW_DATA aborts the fetch
        do_reset();
        setup_basic();
        run_tick(0);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_valid", 32'(o_note_valid), 0);
            chk("abort_note", 32'(o_note), 0);
            chk("abort_busy", 32'(o_busy), 0);
            chk("abort_rom_addr", 32'(o_rom_addr), 0);
            chk("abort_instr", 32'(o_instrument), 0);
        end
        do_reset();
        run_tick(0);
        chk("restart_latency", first_emit, 5);
        chk("restart_note", 32'(o_note), 20);

        // Randomized song
        do_reset();
        rom_clear();
        for (int c = 0; c < NCH; c++) begin
            for (int o = 0; o < OD; o++) begin
                set_order(c, o, int'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)));
            end
        end
        for (int i = 0; i < 520; i++) begin
            rom[PB + i] = {1'($urandom), 4'($urandom), 5'($urandom_range(0, 3)), 6'($urandom)};
        end
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                i_enable = 1'b0; i_tick = 1'b1;
                @(negedge clk);
                i_tick = 1'b0; i_enable = 1'b1;
                @(negedge clk);
                chk("rand_disabled_busy", 32'(o_busy), 0);
            end else begin
                run_tick(0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        chk("rand_no_overrun", 32'(o_overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
